// File: rtl/ws2812_stream_decoder_if.sv
// Output bundle of the WS2812 stream decoder: decoded pixels, frame markers and error status.
// Valid-only stream: pixel_valid, frame_done and err are single-cycle strobes with no back-pressure;
// the data fields are meaningful in the strobe cycle and hold their value until the next strobe.
interface ws2812_stream_decoder_if #(
  parameter int IDX_W = 8
);
  logic [23:0]      pixel_data;
  logic             pixel_valid;
  logic [IDX_W-1:0] pixel_index;
  logic             frame_done;
  logic [IDX_W-1:0] frame_pixels;
  logic             err;
  logic [7:0]       err_count;
  logic             in_sync;

  modport master (
    output pixel_data, pixel_valid, pixel_index, frame_done,
    output frame_pixels, err, err_count, in_sync
  );

  modport slave (
    input pixel_data, pixel_valid, pixel_index, frame_done,
    input frame_pixels, err, err_count, in_sync
  );
endinterface

// File: rtl/ws2812_stream_decoder.sv
// WS2812B NRZ receiver: measures high pulses on a synchronised line, decodes 24-bit pixels,
// detects the frame reset gap and flags glitches, stuck-high lines and truncated words.
module ws2812_stream_decoder #(
  parameter int T_THRESH     = 25,
  parameter int MIN_HIGH     = 4,
  parameter int MAX_HIGH     = 60,
  parameter int RESET_CYCLES = 1600,
  parameter int IDX_W        = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    din,
  ws2812_stream_decoder_if.master px,
  output logic [1:0]              dbg_state
);
  localparam int LOW_W = $clog2(RESET_CYCLES + 1);
  localparam logic [6:0]       T_TH     = 7'(T_THRESH);
  localparam logic [6:0]       MIN_H    = 7'(MIN_HIGH);
  localparam logic [6:0]       MAX_H    = 7'(MAX_HIGH);
  localparam logic [LOW_W-1:0] RST_LAST = LOW_W'(RESET_CYCLES - 1);
  localparam logic [LOW_W-1:0] LOW_ONE  = LOW_W'(1);

  typedef enum logic [1:0] {
    ST_RESYNC = 2'd0,
    ST_IDLE   = 2'd1,
    ST_HIGH   = 2'd2,
    ST_LOW    = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic             s1, s2, s3;
  logic             rise, fall;
  logic [6:0]       high_q, high_d, high_sat;
  logic [LOW_W-1:0] low_q, low_d, low_sat;
  logic [4:0]       bit_cnt_q;
  logic [23:0]      shift_q;
  logic [IDX_W-1:0] pix_cnt_q;
  logic             bit_wr, bit_val, word_done, err_d, frame_end;

  logic [23:0]      pixel_data_q;
  logic             pixel_valid_q;
  logic [IDX_W-1:0] pixel_index_q;
  logic             frame_done_q;
  logic [IDX_W-1:0] frame_pixels_q;
  logic             err_q;
  logic [7:0]       err_count_q;

  assign rise     = s2 & ~s3;
  assign fall     = ~s2 & s3;
  assign high_sat = (high_q == 7'h7f) ? high_q : high_q + 7'd1;
  assign low_sat  = (low_q == {LOW_W{1'b1}}) ? low_q : low_q + LOW_ONE;

  // Synchroniser, FSM state and pulse-width counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1      <= 1'b0;
      s2      <= 1'b0;
      s3      <= 1'b0;
      state_q <= ST_RESYNC;
      high_q  <= '0;
      low_q   <= '0;
    end else begin
      s1      <= din;
      s2      <= s1;
      s3      <= s2;
      state_q <= state_d;
      high_q  <= high_d;
      low_q   <= low_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    high_d    = high_q;
    low_d     = low_q;
    bit_wr    = 1'b0;
    err_d     = 1'b0;
    frame_end = 1'b0;
    bit_val   = (high_q > T_TH);
    case (state_q)
      ST_RESYNC: begin
        if (s2) begin
          low_d = '0;
        end else begin
          low_d = low_sat;
          if (low_q == RST_LAST) state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (rise) begin
          state_d = ST_HIGH;
          high_d  = 7'd1;
        end
      end
      ST_HIGH: begin
        if (s2) begin
          // Stuck line is reported as soon as the limit is crossed, without waiting for a fall.
          if (high_q == MAX_H) begin
            err_d   = 1'b1;
            state_d = ST_RESYNC;
            low_d   = '0;
          end else begin
            high_d = high_sat;
          end
        end else if (fall) begin
          low_d = LOW_ONE;
          if (high_q < MIN_H) begin
            err_d   = 1'b1;
            state_d = ST_RESYNC;
          end else begin
            bit_wr  = 1'b1;
            state_d = ST_LOW;
          end
        end
      end
      ST_LOW: begin
        if (rise) begin
          state_d = ST_HIGH;
          high_d  = 7'd1;
        end else begin
          low_d = low_sat;
          if (low_q == RST_LAST) begin
            frame_end = 1'b1;
            err_d     = (bit_cnt_q != 5'd0);
            state_d   = ST_IDLE;
          end
        end
      end
      default: state_d = ST_RESYNC;
    endcase
  end

  assign word_done = bit_wr && (bit_cnt_q == 5'd23);

  // Word assembly, pixel/frame bookkeeping and registered output strobes.
  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt_q      <= '0;
      shift_q        <= '0;
      pix_cnt_q      <= '0;
      pixel_data_q   <= '0;
      pixel_valid_q  <= 1'b0;
      pixel_index_q  <= '0;
      frame_done_q   <= 1'b0;
      frame_pixels_q <= '0;
      err_q          <= 1'b0;
      err_count_q    <= '0;
    end else begin
      pixel_valid_q <= word_done;
      frame_done_q  <= frame_end;
      err_q         <= err_d;
      if (err_d && (err_count_q != 8'hff)) err_count_q <= err_count_q + 8'd1;
      if (frame_end) frame_pixels_q <= pix_cnt_q;
      // Partial words are discarded simply by restarting the bit position outside a frame.
      if ((state_q == ST_RESYNC) || (state_q == ST_IDLE)) begin
        bit_cnt_q <= '0;
        pix_cnt_q <= '0;
      end else if (bit_wr) begin
        shift_q[bit_cnt_q] <= bit_val;
        if (word_done) begin
          bit_cnt_q     <= '0;
          pixel_data_q  <= {bit_val, shift_q[22:0]};
          pixel_index_q <= pix_cnt_q;
          if (pix_cnt_q != {IDX_W{1'b1}}) pix_cnt_q <= pix_cnt_q + IDX_W'(1);
        end else begin
          bit_cnt_q <= bit_cnt_q + 5'd1;
        end
      end
    end
  end

  assign px.pixel_data   = pixel_data_q;
  assign px.pixel_valid  = pixel_valid_q;
  assign px.pixel_index  = pixel_index_q;
  assign px.frame_done   = frame_done_q;
  assign px.frame_pixels = frame_pixels_q;
  assign px.err          = err_q;
  assign px.err_count    = err_count_q;
  assign px.in_sync      = (state_q != ST_RESYNC);
  assign dbg_state       = state_q;
endmodule

// File: tb/tb_ws2812_stream_decoder.sv
// Bench for ws2812_stream_decoder: line-level stimulus through a segment-based reference model,
// with a scoreboard monitor comparing every pixel, frame and error strobe.
`timescale 1ns/1ps
module tb_ws2812_stream_decoder;
  localparam int IDX_W        = 8;
  localparam int T_THRESH     = 25;
  localparam int MIN_HIGH     = 4;
  localparam int MAX_HIGH     = 60;
  localparam int RESET_CYCLES = 1600;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       din = 1'b0;
  logic [1:0] dbg_state;

  ws2812_stream_decoder_if #(.IDX_W(IDX_W)) bus ();

  ws2812_stream_decoder #(
    .T_THRESH(T_THRESH), .MIN_HIGH(MIN_HIGH), .MAX_HIGH(MAX_HIGH),
    .RESET_CYCLES(RESET_CYCLES), .IDX_W(IDX_W)
  ) dut (
    .clk(clk), .reset(reset), .din(din), .px(bus.master), .dbg_state(dbg_state)
  );

  // Clock and cycle counter
  always #12.5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;
  int err_cyc  = 0;

  // Scoreboard queues: {index, data}, {err, frame_pixels}, expected err_count per err strobe
  logic [IDX_W+23:0] exp_q[$];
  logic [IDX_W:0]    frame_q[$];
  logic [7:0]        err_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Reference model: works on whole line segments (level, duration) rather than cycles
  bit          m_synced, m_idle;
  int          m_accum, m_bits, m_pix, m_errs;
  logic [23:0] m_word, m_last;

  task automatic m_reset();
    m_synced = 1'b0; m_idle = 1'b0; m_accum = 0; m_bits = 0; m_pix = 0; m_errs = 0;
    m_word = '0; m_last = '0;
  endtask

  task automatic m_count_err();
    if (m_errs < 255) m_errs++;
    err_q.push_back(8'(m_errs));
  endtask

  task automatic m_segment(input logic v, input int n);
    if (v) begin
      if (!m_synced) begin
        m_accum = 0;
      end else if (n > MAX_HIGH || n < MIN_HIGH) begin
        m_count_err();
        m_synced = 1'b0;
        m_accum  = 0;
      end else begin
        m_idle = 1'b0;
        m_word[m_bits] = (n > T_THRESH);
        m_bits++;
        if (m_bits == 24) begin
          exp_q.push_back({IDX_W'(m_pix), m_word});
          m_last = m_word;
          if (m_pix < (1 << IDX_W) - 1) m_pix++;
          m_bits = 0;
        end
      end
    end else begin
      if (!m_synced) begin
        m_accum += n;
        if (m_accum >= RESET_CYCLES) begin
          m_synced = 1'b1; m_idle = 1'b1; m_bits = 0; m_pix = 0;
        end
      end else if (!m_idle && n >= RESET_CYCLES) begin
        frame_q.push_back({(m_bits != 0), IDX_W'(m_pix)});
        if (m_bits != 0) m_count_err();
        m_idle = 1'b1; m_bits = 0; m_pix = 0;
      end
    end
  endtask

  // Driver tasks: every segment starts 1 time unit after a rising edge
  task automatic seg(input logic v, input int n);
    m_segment(v, n);
    din = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_range(input logic [23:0] w, input int lo, input int hi,
                            input int last_low, input bit rnd);
    for (int i = lo; i <= hi; i++) begin
      int h, l;
      if (rnd) begin
        h = w[i] ? int'($urandom_range(60, 26)) : int'($urandom_range(25, 4));
        l = int'($urandom_range(40, 2));
      end else begin
        h = w[i] ? 33 : 17;
        l = w[i] ? 19 : 35;
      end
      if (i == hi) l = last_low;
      seg(1'b1, h);
      seg(1'b0, l);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, " pixel_data"},   64'(bus.pixel_data), 64'(0));
    chk({tag, " pixel_valid"},  64'(bus.pixel_valid), 64'(0));
    chk({tag, " pixel_index"},  64'(bus.pixel_index), 64'(0));
    chk({tag, " frame_done"},   64'(bus.frame_done), 64'(0));
    chk({tag, " frame_pixels"}, 64'(bus.frame_pixels), 64'(0));
    chk({tag, " err"},          64'(bus.err), 64'(0));
    chk({tag, " err_count"},    64'(bus.err_count), 64'(0));
    chk({tag, " in_sync"},      64'(bus.in_sync), 64'(0));
  endtask

  task automatic reset_pulse(input string tag);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero(tag);
    reset = 1'b0;
    m_reset();
  endtask

  // Monitor: pops the scoreboard on every strobe the DUT presents
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.pixel_valid) begin
        if (exp_q.size() == 0) chk("spurious pixel_valid", 64'(bus.pixel_valid), 64'(0));
        else chk("pixel index/data", 64'({bus.pixel_index, bus.pixel_data}), 64'(exp_q.pop_front()));
      end
      if (bus.frame_done) begin
        if (frame_q.size() == 0) chk("spurious frame_done", 64'(bus.frame_done), 64'(0));
        else chk("frame err/pixels", 64'({bus.err, bus.frame_pixels}), 64'(frame_q.pop_front()));
      end
      if (bus.err) begin
        err_cyc = cyc;
        if (err_q.size() == 0) chk("spurious err", 64'(bus.err), 64'(0));
        else chk("err_count at err", 64'(bus.err_count), 64'(err_q.pop_front()));
      end
    end
  end

  initial begin
    repeat (99000) @(posedge clk);
    $display("FAIL watchdog: cycle budget exhausted at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // Main sequence
  logic [23:0] six_px[6];
  logic [23:0] w;
  int          t0, npx;

  initial begin
    six_px = '{24'h00b000, 24'h00f060, 24'h00b0b0, 24'h0000b0, 24'hb00000, 24'h909090};
    m_reset();
    repeat (4) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b0;
    m_reset();

    // Single pixel with nominal timing
    seg(1'b0, 1600);
    send_range(24'h00b000, 0, 23, 2001, 1'b0);
    chk("in_sync after frame", 64'(bus.in_sync), 64'(1));

    // Six pixels with 2-cycle inter-pixel gaps
    for (int p = 0; p < 6; p++) send_range(six_px[p], 0, 23, (p == 5) ? 2001 : 2, 1'b0);

    // Threshold boundary: 25 decodes as 0, 26 as 1
    seg(1'b1, 25); seg(1'b0, 27);
    seg(1'b1, 26); seg(1'b0, 26);
    send_range(24'h000000, 2, 23, 2001, 1'b0);

    // Glitch mid-word, ignored pixel during resync, then a decoded pixel
    send_range(24'h123456, 0, 5, 35, 1'b0);
    seg(1'b1, 3);
    seg(1'b0, 1000);
    chk("in_sync after glitch", 64'(bus.in_sync), 64'(0));
    chk("err_count after glitch", 64'(bus.err_count), 64'(m_errs));
    chk("pixel_data held after err", 64'(bus.pixel_data), 64'(m_last));
    send_range(24'hffffff, 0, 23, 1600, 1'b0);
    send_range(24'h5a0ff0, 0, 23, 2001, 1'b0);

    // Stuck-high: err lands 63 edges after din rises (2 sync stages + 61 counted cycles)
    t0 = cyc;
    seg(1'b1, 61);
    seg(1'b0, 1700);
    chk("stuck-high err cycle", 64'(err_cyc - t0), 64'(63));
    chk("in_sync after resync", 64'(bus.in_sync), 64'(1));

    // Partial word at frame end
    send_range(24'h3ff, 0, 9, 1600, 1'b0);
    seg(1'b0, 20);

    // Reset mid-word, stream continues, then resync and decode from index 0
    send_range(24'hc3a5e1, 0, 11, 35, 1'b0);
    reset_pulse("mid-word reset");
    send_range(24'hc3a5e1, 12, 23, 35, 1'b0);
    seg(1'b0, 2001);
    send_range(24'h0a0b0c, 0, 23, 2001, 1'b0);

    // Randomized frames with random legal timing, plus injected glitch and stuck-high faults
    for (int f = 0; f < 4; f++) begin
      if (f == 1 || f == 3) begin
        w = 24'($urandom);
        send_range(w, 0, 7, int'($urandom_range(40, 2)), 1'b1);
        seg(1'b1, (f == 1) ? int'($urandom_range(3, 1)) : int'($urandom_range(75, 61)));
        seg(1'b0, 1700);
      end
      npx = int'($urandom_range(4, 1));
      for (int p = 0; p < npx; p++) begin
        w = 24'($urandom);
        send_range(w, 0, 23,
                   (p == npx - 1) ? int'($urandom_range(1700, 1600)) : int'($urandom_range(40, 2)),
                   1'b1);
      end
    end

    // Drain and final report
    seg(1'b0, 40);
    chk("pixel queue drained", 64'(exp_q.size()), 64'(0));
    chk("frame queue drained", 64'(frame_q.size()), 64'(0));
    chk("err queue drained", 64'(err_q.size()), 64'(0));
    chk("final err_count", 64'(bus.err_count), 64'(m_errs));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
